// File: rtl/iou_pkg.sv
// Shared constants for the IOU display/edit block: register map, status bit
// positions and the hex-to-7-segment glyph table.
package iou_pkg;

  // Register addresses
  localparam logic [7:0] ADDR_LED    = 8'h00;
  localparam logic [7:0] ADDR_RAW    = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_SEG    = 8'h0C;
  localparam logic [7:0] ADDR_VLD    = 8'h10;
  localparam logic [7:0] ADDR_SWX    = 8'h14;
  localparam logic [7:0] ADDR_CNT    = 8'h18;

  // Status register bit positions
  localparam int unsigned STAT_RDY   = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_OVF   = 2;
  localparam int unsigned STAT_CNT   = 8;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Circular display-data queue with occupancy count and head output.
// Push while full and pop while empty are ignored.
module seg_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/iou_fifo.sv
// Switch/button I/O unit: hex edit buffer driven by switch and delete presses,
// confirm-to-register handoff, display queue, free-running counter and a
// multiplexed 7-segment scanner, all behind a small register interface.
module iou_fifo
  import iou_pkg::*;
#(
  parameter int unsigned SW_W       = 16,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCAN_DIV   = 100
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              data,
  input  logic              del,
  input  logic [SW_W-1:0]   x,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [SW_W-1:0]   led,
  input  logic [7:0]        io_addr,
  input  logic [31:0]       io_dout,
  input  logic              io_we,
  input  logic              io_rd,
  output logic [31:0]       io_din
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SW_W-1:0] x_q;
  logic            del_q;
  logic            data_q;
  logic [SW_W-1:0] sw_press;
  logic            any_sw;
  logic [3:0]      sw_digit;
  logic            del_press;
  logic            data_press;

  logic [BW-1:0]   edit_q;
  logic [BW-1:0]   edit_d;
  logic [BW+3:0]   edit_shl;
  logic [31:0]     edit_ext;
  logic [31:0]     swx_data_q;
  logic            swx_vld_q;
  logic            ovf_q;
  logic [31:0]     counter_q;
  logic [SW_W-1:0] led_q;
  logic [DW-1:0]   div_q;
  logic [IW-1:0]   idx_q;

  logic            wr_led, wr_stat, wr_seg, wr_cnt, rd_swx;
  logic            push, pop, confirm;
  logic            full, empty;
  logic [CW-1:0]   count;
  logic [31:0]     head;
  logic [31:0]     disp;
  logic [3:0]      nib;

  // Press detection: rising edge against last cycle's level
  always_comb begin
    sw_press   = x & ~x_q;
    any_sw     = |sw_press;
    del_press  = del & ~del_q;
    data_press = data & ~data_q;
    sw_digit   = 4'h0;
    for (int i = SW_W - 1; i >= 0; i--) begin
      if (sw_press[i]) sw_digit = 4'(i);
    end
  end

  assign wr_led  = io_we && (io_addr == ADDR_LED);
  assign wr_stat = io_we && (io_addr == ADDR_STATUS);
  assign wr_seg  = io_we && (io_addr == ADDR_SEG);
  assign wr_cnt  = io_we && (io_addr == ADDR_CNT);
  assign rd_swx  = io_rd && (io_addr == ADDR_SWX);

  assign push    = wr_seg && !full;
  assign pop     = !empty && (any_sw || del_press);
  // A switch press in the same cycle swallows the confirm
  assign confirm = data_press && !swx_vld_q && !any_sw;

  seg_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_seg_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .wdata (io_dout),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Edit buffer next state: edits only apply while the queue is empty
  always_comb begin
    edit_shl = {edit_q, sw_digit};
    edit_d   = edit_q;
    if (empty && any_sw) begin
      edit_d = edit_shl[BW-1:0];
    end else if (confirm) begin
      edit_d = '0;
    end else if (empty && del_press) begin
      edit_d = edit_q >> 4;
    end
  end

  // Zero-extended copy of the edit buffer for handoff and display
  always_comb begin
    edit_ext         = '0;
    edit_ext[BW-1:0] = edit_q;
  end

  // Core state: edge registers, edit/handoff, overflow, LED and counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_q        <= '0;
      del_q      <= 1'b0;
      data_q     <= 1'b0;
      edit_q     <= '0;
      swx_data_q <= '0;
      swx_vld_q  <= 1'b0;
      ovf_q      <= 1'b0;
      counter_q  <= '0;
      led_q      <= '1;
    end else begin
      x_q    <= x;
      del_q  <= del;
      data_q <= data;
      edit_q <= edit_d;
      if (confirm) swx_data_q <= edit_ext;
      // Set and clear both judged against the current flag, so they never collide
      swx_vld_q <= swx_vld_q ? !rd_swx : confirm;
      if (wr_seg && full) ovf_q <= 1'b1;
      else if (wr_stat)   ovf_q <= 1'b0;
      counter_q <= wr_cnt ? io_dout : counter_q + 32'd1;
      if (wr_led) led_q <= io_dout[SW_W-1:0];
    end
  end

  // Digit scan: divider terminal count advances the digit index
  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DW'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Display source selection, digit select and glyph lookup
  always_comb begin
    disp = empty ? edit_ext : head;
    nib  = 4'h0;
    an   = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib   = disp[4*k +: 4];
        an[k] = 1'b0;
      end
    end
    seg = hex2seg(nib);
  end

  assign led = led_q;

  // Register read mux
  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_LED:    io_din[SW_W-1:0] = led_q;
      ADDR_RAW:    io_din[SW_W+1:0] = {data, del, x};
      ADDR_STATUS: begin
        io_din[STAT_RDY]       = !full;
        io_din[STAT_EMPTY]     = empty;
        io_din[STAT_OVF]       = ovf_q;
        io_din[STAT_CNT +: CW] = count;
      end
      ADDR_VLD:    io_din[0] = swx_vld_q;
      ADDR_SWX:    io_din = swx_data_q;
      ADDR_CNT:    io_din = counter_q;
      default:     io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_iou_fifo.sv
// Self-checking bench for iou_fifo: directed scenarios followed by random
// stimulus, compared against a queue/arithmetic reference model.
module tb_iou_fifo;

  localparam int SW_W   = 16;
  localparam int DIGITS = 8;
  localparam int DEPTH  = 4;
  localparam int SDIV   = 2;
  localparam longint unsigned BUF_MOD = 64'd1 << (4 * DIGITS);

  logic        clk = 1'b0;
  logic        rstn, data, del;
  logic [15:0] x;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic [15:0] led;
  logic [7:0]  io_addr;
  logic [31:0] io_dout, io_din;
  logic        io_we, io_rd;

  always #5 clk = ~clk;

  iou_fifo #(
    .SW_W       (SW_W),
    .DIGITS     (DIGITS),
    .FIFO_DEPTH (DEPTH),
    .SCAN_DIV   (SDIV)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .data    (data),
    .del     (del),
    .x       (x),
    .seg     (seg),
    .an      (an),
    .led     (led),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_rd   (io_rd),
    .io_din  (io_din)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state
  logic [31:0]       m_q[$];
  longint unsigned   m_buf;
  logic              m_vld;
  logic [31:0]       m_swx;
  logic              m_ovf;
  logic [31:0]       m_cnt;
  logic [15:0]       m_led;
  int                m_cyc;
  logic [15:0]       p_x;
  logic              p_del, p_data;

  // Lit segments of each hex glyph
  string lit_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg",
                          "aefg"};

  function automatic logic [6:0] glyph(input int h);
    logic [6:0] g;
    g = 7'h7F;
    for (int i = 0; i < lit_segs[h].len(); i++) g[int'(lit_segs[h][i]) - 97] = 1'b0;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    int sz;
    sz = m_q.size();
    case (a)
      8'h00:   r = {16'h0, m_led};
      8'h04:   r = {14'h0, data, del, x};
      8'h08:   r = (32'(sz) << 8) | (32'(m_ovf) << 2) | (32'(sz == 0) << 1) | 32'(sz < DEPTH);
      8'h10:   r = {31'h0, m_vld};
      8'h14:   r = m_swx;
      8'h18:   r = m_cnt;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Apply one clock edge's worth of behaviour using the inputs present at the edge
  task automatic model_edge();
    logic [15:0] sp;
    logic        anysw, dp, cp, conf, empty0, old_vld;
    int          d, sz0;
    if (!rstn) begin
      m_q.delete();
      m_buf = 0; m_vld = 0; m_swx = 0; m_ovf = 0; m_cnt = 0; m_led = '1; m_cyc = 0;
      p_x = 0; p_del = 0; p_data = 0;
      return;
    end
    sp    = x & ~p_x;
    anysw = (sp != 0);
    dp    = del && !p_del;
    cp    = data && !p_data;
    d     = 0;
    for (int i = 15; i >= 0; i--) if (sp[i]) d = i;
    sz0     = m_q.size();
    empty0  = (sz0 == 0);
    old_vld = m_vld;
    conf    = cp && !old_vld && !anysw;
    if (!empty0 && (anysw || dp)) void'(m_q.pop_front());
    if (io_we && io_addr == 8'h0C) begin
      if (sz0 < DEPTH) m_q.push_back(io_dout);
      else m_ovf = 1;
    end
    if (io_we && io_addr == 8'h08) m_ovf = 0;
    if (anysw && empty0) m_buf = (m_buf * 16 + longint'(d)) % BUF_MOD;
    else if (conf) begin
      m_swx = m_buf[31:0];
      m_buf = 0;
    end else if (dp && empty0) m_buf = m_buf / 16;
    if (old_vld && io_rd && io_addr == 8'h14) m_vld = 0;
    if (!old_vld && conf) m_vld = 1;
    m_cnt = (io_we && io_addr == 8'h18) ? io_dout : m_cnt + 1;
    if (io_we && io_addr == 8'h00) m_led = io_dout[15:0];
    p_x = x; p_del = del; p_data = data;
    m_cyc++;
  endtask

  task automatic check_disp();
    int          idx;
    logic [31:0] disp;
    idx  = (m_cyc / SDIV) % DIGITS;
    disp = (m_q.size() != 0) ? m_q[0] : m_buf[31:0];
    chk("an", {24'h0, an}, {24'h0, ~(8'h01 << idx)});
    chk("seg", {25'h0, seg}, {25'h0, glyph(int'((disp >> (4 * idx)) & 32'hF))});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_disp();
    io_we = 1'b0;
    io_rd = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string tag, output logic [31:0] v);
    io_addr = a;
    #1;
    v = io_din;
    chk(tag, v, model_read(a));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] val);
    io_we   = 1'b1;
    io_addr = a;
    io_dout = val;
    step();
  endtask

  task automatic press_x(input int i);
    x[i] = 1'b1; step();
    x[i] = 1'b0; step();
  endtask

  task automatic press_del();
    del = 1'b1; step();
    del = 1'b0; step();
  endtask

  task automatic press_data();
    data = 1'b1; step();
    data = 1'b0; step();
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  addrs[7] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C};
    int          r;

    rstn = 1'b0; data = 1'b0; del = 1'b0; x = '0;
    io_we = 1'b0; io_rd = 1'b0; io_addr = '0; io_dout = '0;
    step(); step();

    // Reset state
    chk("rst_an", {24'h0, an}, 32'hFE);
    chk("rst_seg", {25'h0, seg}, 32'h40);
    rd(8'h08, "rst_status", v); chk("rst_status_val", v, 32'h3);
    rd(8'h00, "rst_led", v);    chk("rst_led_val", v, 32'hFFFF);
    rd(8'h18, "rst_cnt", v);
    rstn = 1'b1;
    step();

    // Fill past capacity
    for (int k = 1; k <= 5; k++) wr(8'h0C, 32'h11111111 * k);
    rd(8'h08, "full_status", v); chk("full_status_val", v, 32'h404);
    wr(8'h08, 32'h0);
    rd(8'h08, "ovf_clear", v);
    for (int k = 0; k < 4; k++) press_del();
    rd(8'h08, "drained", v);    chk("drained_val", v, 32'h3);

    // Editing on an empty queue
    press_x(3);
    press_x(10);
    press_del();
    x = 16'h8004; step();
    x = 16'h0000; step();

    // Confirm handoff
    press_data();
    rd(8'h10, "vld_set", v);    chk("vld_set_val", v, 32'h1);
    rd(8'h14, "swx_data", v);   chk("swx_data_val", v, 32'h32);
    press_x(7);
    press_data();
    rd(8'h14, "swx_hold", v);   chk("swx_hold_val", v, 32'h32);
    io_rd = 1'b1; io_addr = 8'h14; step();
    rd(8'h10, "vld_clr", v);    chk("vld_clr_val", v, 32'h0);

    // Press pops queue head and leaves edit buffer alone
    wr(8'h0C, 32'hDEADBEEF);
    wr(8'h0C, 32'h12345678);
    press_x(0);
    rd(8'h08, "pop_status", v); chk("pop_status_val", v, 32'h101);
    press_del();
    press_data();
    rd(8'h14, "buf_kept", v);   chk("buf_kept_val", v, 32'h7);

    // Counter wrap
    wr(8'h18, 32'hFFFFFFFE);
    rd(8'h18, "cnt_load", v);
    step();
    rd(8'h18, "cnt_ff", v);     chk("cnt_ff_val", v, 32'hFFFFFFFF);
    step();
    rd(8'h18, "cnt_wrap", v);   chk("cnt_wrap_val", v, 32'h0);

    // Scan walk, then reset mid-scan
    for (int k = 0; k < 19; k++) step();
    rstn = 1'b0; step();
    chk("scan_rst_an", {24'h0, an}, 32'hFE);
    rstn = 1'b1; step();

    // Reset mid-operation with a held switch and queued entries
    wr(8'h0C, 32'hAAAA5555);
    x[5] = 1'b1;
    rstn = 1'b0; step();
    rd(8'h08, "midrst_status", v); chk("midrst_status_val", v, 32'h3);
    rstn = 1'b1; step();
    x[5] = 1'b0; step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) x = x ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) x = x ^ 16'h0101;
      if ($urandom_range(0, 4) == 0) del = ~del;
      if ($urandom_range(0, 6) == 0) data = ~data;
      r = $urandom_range(0, 99);
      io_dout = $urandom;
      if (r < 18) begin io_we = 1'b1; io_addr = 8'h0C; end
      else if (r < 22) begin io_we = 1'b1; io_addr = 8'h08; end
      else if (r < 24) begin io_we = 1'b1; io_addr = 8'h18; end
      else if (r < 27) begin io_we = 1'b1; io_addr = 8'h00; end
      else if (r < 29) begin io_we = 1'b1; io_addr = 8'h1C; end
      else if (r < 40) begin io_rd = 1'b1; io_addr = 8'h14; end
      rstn = ($urandom_range(0, 149) != 0);
      step();
      rd(addrs[$urandom_range(0, 6)], "rand_read", v);
      rd(8'h08, "rand_status", v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
